// File: rtl/fft_frame_scheduler.sv
// Frame sequencer for the FFT engine: ping-pong input buffer writes, start handshake
// with the address generator, bank ownership tracking, overrun and start-timeout status.
module fft_frame_scheduler #(
  parameter int N_LOG2    = 10,
  parameter int START_TMO = 16,
  parameter int OVR_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_i,
  input  logic              sample_valid_i,
  output logic              wr_en_o,
  output logic              wr_bank_o,
  output logic [N_LOG2-1:0] wr_addr_o,
  output logic              rd_bank_o,
  output logic              fft_start_o,
  input  logic              fft_loading_i,
  input  logic              fft_done_i,
  input  logic              vga_busy_i,
  output logic [OVR_W-1:0]  overrun_cnt_o,
  output logic              tmo_err_o,
  output logic              busy_o
);
  localparam int TMO_W = $clog2(START_TMO + 1);
  localparam logic [N_LOG2-1:0] PTR_LAST = {N_LOG2{1'b1}};
  localparam logic [N_LOG2-1:0] PTR_ONE  = N_LOG2'(1);
  localparam logic [OVR_W-1:0]  OVR_MAX  = {OVR_W{1'b1}};
  localparam logic [OVR_W-1:0]  OVR_ONE  = OVR_W'(1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(START_TMO - 1);
  localparam logic [TMO_W-1:0]  TMO_ONE  = TMO_W'(1);

  typedef enum logic [1:0] {
    B_FREE    = 2'd0,
    B_FILLING = 2'd1,
    B_READY   = 2'd2,
    B_READING = 2'd3
  } bank_st_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_LOADING = 3'd2,
    S_COMPUTE = 3'd3,
    S_OUTPUT  = 3'd4,
    S_HOLD    = 3'd5
  } state_e;

  state_e            state_r;
  bank_st_e          bank_r    [2];
  bank_st_e          bank_nx_s [2];
  logic              wr_bank_r;
  logic [N_LOG2-1:0] wr_ptr_r;
  logic [TMO_W-1:0]  tmo_cnt_r;
  logic              hold_cnt_r;
  logic              accept_s, wrap_s, other_free_s;
  logic              grab_s, grab_bank_s, tmo_s, release_s;

  // Per-cycle events shared by the write side and the frame FSM
  always_comb begin
    accept_s    = enable_i & sample_valid_i;
    wrap_s      = accept_s & (wr_ptr_r == PTR_LAST);
    grab_s      = 1'b0;
    grab_bank_s = 1'b0;
    if ((state_r == S_IDLE) && enable_i && !vga_busy_i) begin
      if (bank_r[0] == B_READY) begin
        grab_s      = 1'b1;
        grab_bank_s = 1'b0;
      end else if (bank_r[1] == B_READY) begin
        grab_s      = 1'b1;
        grab_bank_s = 1'b1;
      end else begin
        grab_s      = 1'b0;
        grab_bank_s = 1'b0;
      end
    end else begin
      grab_s      = 1'b0;
      grab_bank_s = 1'b0;
    end
    tmo_s     = (state_r == S_START) & !fft_loading_i & (tmo_cnt_r == TMO_LAST);
    release_s = (state_r == S_LOADING) & !fft_loading_i;
    // A bank released this very cycle counts as free, so the wrap does not overrun
    other_free_s = (bank_r[~wr_bank_r] == B_FREE) | (release_s & (rd_bank_o != wr_bank_r));
  end

  // Next bank ownership: FSM transitions first, a successful wrap overrides them
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_nx_s[b] = bank_r[b];
      if (grab_s && (grab_bank_s == 1'(b))) begin
        bank_nx_s[b] = B_READING;
      end else if (tmo_s && (rd_bank_o == 1'(b))) begin
        bank_nx_s[b] = B_READY;
      end else if (release_s && (rd_bank_o == 1'(b))) begin
        bank_nx_s[b] = B_FREE;
      end else begin
        bank_nx_s[b] = bank_r[b];
      end
      if (wrap_s && other_free_s) begin
        bank_nx_s[b] = (wr_bank_r == 1'(b)) ? B_READY : B_FILLING;
      end else begin
        bank_nx_s[b] = bank_nx_s[b];
      end
    end
  end

  // Write side: buffer strobes, write pointer, bank toggle and overrun counting
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_r[0]     <= B_FILLING;
      bank_r[1]     <= B_FREE;
      wr_bank_r     <= 1'b0;
      wr_ptr_r      <= '0;
      wr_en_o       <= 1'b0;
      wr_bank_o     <= 1'b0;
      wr_addr_o     <= '0;
      overrun_cnt_o <= '0;
    end else begin
      bank_r[0] <= bank_nx_s[0];
      bank_r[1] <= bank_nx_s[1];
      wr_en_o   <= accept_s;
      wr_bank_o <= wr_bank_r;
      wr_addr_o <= wr_ptr_r;
      if (wrap_s) begin
        wr_ptr_r <= '0;
        if (other_free_s) begin
          wr_bank_r <= ~wr_bank_r;
        end else if (overrun_cnt_o != OVR_MAX) begin
          overrun_cnt_o <= overrun_cnt_o + OVR_ONE;
        end
      end else if (accept_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
    end
  end

  // Frame FSM with registered start pulse, read bank, busy and timeout flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      rd_bank_o   <= 1'b0;
      fft_start_o <= 1'b0;
      tmo_err_o   <= 1'b0;
      busy_o      <= 1'b0;
      tmo_cnt_r   <= '0;
      hold_cnt_r  <= 1'b0;
    end else begin
      fft_start_o <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (grab_s) begin
            state_r     <= S_START;
            rd_bank_o   <= grab_bank_s;
            fft_start_o <= 1'b1;
            busy_o      <= 1'b1;
            tmo_cnt_r   <= '0;
          end
        end
        S_START: begin
          if (fft_loading_i) begin
            state_r <= S_LOADING;
          end else if (tmo_s) begin
            tmo_err_o <= 1'b1;
            state_r   <= S_IDLE;
            busy_o    <= 1'b0;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
          end
        end
        S_LOADING: begin
          if (release_s) state_r <= S_COMPUTE;
        end
        S_COMPUTE: begin
          if (fft_done_i) state_r <= S_OUTPUT;
        end
        S_OUTPUT: begin
          if (!fft_done_i) begin
            state_r    <= S_HOLD;
            hold_cnt_r <= 1'b0;
          end
        end
        S_HOLD: begin
          // Two cycles minimum so the VGA block can raise vga_busy_i
          if (hold_cnt_r && !vga_busy_i) begin
            state_r <= S_IDLE;
            busy_o  <= 1'b0;
          end else begin
            hold_cnt_r <= 1'b1;
          end
        end
        default: begin
          state_r <= S_IDLE;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end
endmodule
